// File: rtl/ping_pong_scheduler_pkg.sv
// ping_pong_scheduler_pkg
//   Definitions shared by the ping-pong character buffer and its scheduler:
//   the scheduler state encoding and default widths for PCs, characters,
//   FIFO occupancy and the in-flight instruction counter.
package ping_pong_scheduler_pkg;

    localparam int unsigned PP_DATA_WIDTH     = 9;
    localparam int unsigned PP_COUNT_WIDTH    = 5;
    localparam int unsigned PP_CHAR_WIDTH     = 8;
    localparam int unsigned PP_INFLIGHT_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_SWAP  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_e;

endpackage

// File: rtl/ping_pong_scheduler_inflight_counter.sv
// inflight_counter
//   Up/down count of instructions handed to the execution engine and not yet
//   retired. Increment and decrement in the same cycle cancel. The count
//   never wraps: increments stop at all-ones and decrements stop at zero.
//
// Ports
//   clk      clock
//   rst      synchronous active-high reset, clears the count
//   inc_i    one instruction dispatched this cycle
//   dec_i    one instruction retired this cycle
//   count_o  current number of in-flight instructions
//   zero_o   count is zero
//   max_o    count is at its maximum (all ones)
module inflight_counter
    import ping_pong_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = PP_INFLIGHT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o,
    output logic             max_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign zero_o  = (count_q == '0);
    assign max_o   = (count_q == {WIDTH{1'b1}});
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !max_o) begin
            count_d = count_q + WIDTH'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ping_pong_scheduler.sv
// ping_pong_scheduler
//   Sits in front of the ping-pong character buffer. Owns the buffer role
//   select, pops PCs from the current-character FIFO into a one-entry
//   dispatch slot, hands them to the execution engine with the current
//   character, tracks in-flight work, swaps buffers and fetches the next
//   character once the current one is drained, and reports match/no-match.
//   After an accept both FIFOs are flushed before reporting.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, start_pc          begin a match from start_pc (IDLE/DONE only)
//   char_in_*                input character stream (valid/ready/data/last)
//   cur_is_even_character    buffer role select, registered
//   cur_fifo_*               current-character FIFO head (FWFT) and pop
//   next_fifo_*              next-character FIFO status and pop (drain only)
//   dispatch_*               instruction to engine (registered valid/pc/char)
//   retire                   one pulse per retired instruction
//   accept                   engine reached an accept instruction
//   done, match              result, match valid while done is high
//
// State table
//   state  | meaning
//   IDLE   | waiting for start after reset
//   FETCH  | fetching the first character; slot is loaded with start_pc
//   RUN    | dispatching PCs of the current character
//   SWAP   | current character drained; fetching the next one
//   DRAIN  | accept seen; flushing both FIFOs and waiting for retires
//   DONE   | result held until the next start
module ping_pong_scheduler
    import ping_pong_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = PP_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH    = PP_COUNT_WIDTH,
    parameter int unsigned CHAR_WIDTH     = PP_CHAR_WIDTH,
    parameter int unsigned INFLIGHT_WIDTH = PP_INFLIGHT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  start_pc,

    input  logic                   char_in_valid,
    output logic                   char_in_ready,
    input  logic [CHAR_WIDTH-1:0]  char_in_data,
    input  logic                   char_in_last,

    output logic                   cur_is_even_character,

    input  logic                   cur_fifo_valid,
    input  logic [DATA_WIDTH-1:0]  cur_fifo_data,
    output logic                   cur_fifo_ready,

    input  logic                   next_fifo_valid,
    output logic                   next_fifo_ready,
    input  logic [COUNT_WIDTH-1:0] next_fifo_count,

    output logic                   dispatch_valid,
    input  logic                   dispatch_ready,
    output logic [DATA_WIDTH-1:0]  dispatch_pc,
    output logic [CHAR_WIDTH-1:0]  dispatch_char,

    input  logic                   retire,
    input  logic                   accept,

    output logic                   done,
    output logic                   match
);

    localparam logic [INFLIGHT_WIDTH:0] INFLIGHT_MAX = {1'b0, {INFLIGHT_WIDTH{1'b1}}};

    sched_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] start_pc_q, start_pc_d;
    logic [DATA_WIDTH-1:0] slot_pc_q, slot_pc_d;
    logic                  slot_valid_q, slot_valid_d;
    logic [CHAR_WIDTH-1:0] char_q, char_d;
    logic                  last_q, last_d;
    logic                  cur_even_q, cur_even_d;
    logic                  done_q, done_d;
    logic                  match_q, match_d;

    logic [INFLIGHT_WIDTH-1:0] inflight;
    logic                      inflight_zero;
    logic                      inflight_max;
    logic [INFLIGHT_WIDTH:0]   committed;
    logic                      take;
    logic                      room;

    // A handshake always counts, even in the cycle accept discards the slot:
    // the engine has taken the instruction and will retire it.
    assign take = slot_valid_q && dispatch_ready;

    // Instructions already in flight plus the one parked in the slot. A new
    // pop is allowed only if that total is still below the counter maximum,
    // so the counter can never be asked to go past all-ones.
    assign committed = {1'b0, inflight} + {{INFLIGHT_WIDTH{1'b0}}, slot_valid_q};
    assign room      = !inflight_max && (committed < INFLIGHT_MAX);

    inflight_counter #(
        .WIDTH (INFLIGHT_WIDTH)
    ) u_inflight (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (take),
        .dec_i   (retire),
        .count_o (inflight),
        .zero_o  (inflight_zero),
        .max_o   (inflight_max)
    );

    always_comb begin
        state_d         = state_q;
        start_pc_d      = start_pc_q;
        slot_pc_d       = slot_pc_q;
        slot_valid_d    = slot_valid_q && !take;
        char_d          = char_q;
        last_d          = last_q;
        cur_even_d      = cur_even_q;
        done_d          = done_q;
        match_d         = match_q;
        char_in_ready   = 1'b0;
        cur_fifo_ready  = 1'b0;
        next_fifo_ready = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_pc_d = start_pc;
                    done_d     = 1'b0;
                    match_d    = 1'b0;
                    state_d    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                char_in_ready = 1'b1;
                if (char_in_valid) begin
                    char_d       = char_in_data;
                    last_d       = char_in_last;
                    slot_valid_d = 1'b1;
                    slot_pc_d    = start_pc_q;
                    state_d      = ST_RUN;
                end
            end

            ST_RUN: begin
                if (accept) begin
                    match_d      = 1'b1;
                    slot_valid_d = 1'b0;
                    state_d      = ST_DRAIN;
                end else if ((!slot_valid_q || take) && cur_fifo_valid && room) begin
                    cur_fifo_ready = 1'b1;
                    slot_valid_d   = 1'b1;
                    slot_pc_d      = cur_fifo_data;
                end else if (!slot_valid_q && !cur_fifo_valid && inflight_zero && !retire) begin
                    // Current character fully drained. Nothing queued for the
                    // next character, or no next character: no match.
                    if ((next_fifo_count == '0) || last_q) begin
                        done_d  = 1'b1;
                        match_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SWAP;
                    end
                end
            end

            ST_SWAP: begin
                char_in_ready = 1'b1;
                if (char_in_valid) begin
                    cur_even_d = !cur_even_q;
                    char_d     = char_in_data;
                    last_d     = char_in_last;
                    state_d    = ST_RUN;
                end
            end

            ST_DRAIN: begin
                cur_fifo_ready  = cur_fifo_valid;
                next_fifo_ready = next_fifo_valid;
                if (!cur_fifo_valid && !next_fifo_valid && inflight_zero) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_pc_q   <= '0;
            slot_pc_q    <= '0;
            slot_valid_q <= 1'b0;
            char_q       <= '0;
            last_q       <= 1'b0;
            cur_even_q   <= 1'b1;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_pc_q   <= start_pc_d;
            slot_pc_q    <= slot_pc_d;
            slot_valid_q <= slot_valid_d;
            char_q       <= char_d;
            last_q       <= last_d;
            cur_even_q   <= cur_even_d;
            done_q       <= done_d;
            match_q      <= match_d;
        end
    end

    assign cur_is_even_character = cur_even_q;
    assign dispatch_valid        = slot_valid_q;
    assign dispatch_pc           = slot_pc_q;
    assign dispatch_char         = char_q;
    assign done                  = done_q;
    assign match                 = match_q;

endmodule

// File: tb/tb_ping_pong_scheduler.sv
module tb_ping_pong_scheduler;

    localparam int DW = 9;
    localparam int CW = 5;
    localparam int HW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] start_pc;
    logic          char_in_valid;
    logic          char_in_ready;
    logic [HW-1:0] char_in_data;
    logic          char_in_last;
    logic          cur_is_even_character;
    logic          cur_fifo_valid;
    logic [DW-1:0] cur_fifo_data;
    logic          cur_fifo_ready;
    logic          next_fifo_valid;
    logic          next_fifo_ready;
    logic [CW-1:0] next_fifo_count;
    logic          dispatch_valid;
    logic          dispatch_ready;
    logic [DW-1:0] dispatch_pc;
    logic [HW-1:0] dispatch_char;
    logic          retire;
    logic          accept;
    logic          done;
    logic          match;

    ping_pong_scheduler #(
        .DATA_WIDTH     (DW),
        .COUNT_WIDTH    (CW),
        .CHAR_WIDTH     (HW),
        .INFLIGHT_WIDTH (IW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .start_pc              (start_pc),
        .char_in_valid         (char_in_valid),
        .char_in_ready         (char_in_ready),
        .char_in_data          (char_in_data),
        .char_in_last          (char_in_last),
        .cur_is_even_character (cur_is_even_character),
        .cur_fifo_valid        (cur_fifo_valid),
        .cur_fifo_data         (cur_fifo_data),
        .cur_fifo_ready        (cur_fifo_ready),
        .next_fifo_valid       (next_fifo_valid),
        .next_fifo_ready       (next_fifo_ready),
        .next_fifo_count       (next_fifo_count),
        .dispatch_valid        (dispatch_valid),
        .dispatch_ready        (dispatch_ready),
        .dispatch_pc           (dispatch_pc),
        .dispatch_char         (dispatch_char),
        .retire                (retire),
        .accept                (accept),
        .done                  (done),
        .match                 (match)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [HW-1:0] ch;
    } disp_t;

    int    even_q[$];
    int    odd_q[$];
    disp_t sb[$];
    int    pending;
    int    n_disp;
    int    total;
    int    bad;
    logic  smp_cur_pop;
    logic  smp_next_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_disp(input int pc, input logic [HW-1:0] ch);
        disp_t e;
        e.pc = DW'(pc);
        e.ch = ch;
        sb.push_back(e);
    endtask

    task automatic push_cur(input int pc);
        if (cur_is_even_character) even_q.push_back(pc);
        else odd_q.push_back(pc);
    endtask

    task automatic push_next(input int pc);
        if (cur_is_even_character) odd_q.push_back(pc);
        else even_q.push_back(pc);
    endtask

    task automatic drive_fifos();
        if (cur_is_even_character === 1'b1) begin
            cur_fifo_valid  = (even_q.size() != 0);
            cur_fifo_data   = (even_q.size() != 0) ? DW'(even_q[0]) : '0;
            next_fifo_valid = (odd_q.size() != 0);
            next_fifo_count = CW'(odd_q.size());
        end else begin
            cur_fifo_valid  = (odd_q.size() != 0);
            cur_fifo_data   = (odd_q.size() != 0) ? DW'(odd_q[0]) : '0;
            next_fifo_valid = (even_q.size() != 0);
            next_fifo_count = CW'(even_q.size());
        end
    endtask

    // One clock: present FIFO views, sample handshakes just before the edge,
    // then update the FIFO/engine model and score any dispatch.
    task automatic cycle();
        logic          hs;
        logic          ev;
        logic [DW-1:0] pc_s;
        logic [HW-1:0] ch_s;
        disp_t         e;
        drive_fifos();
        #1;
        smp_cur_pop  = cur_fifo_ready && cur_fifo_valid;
        smp_next_pop = next_fifo_ready && next_fifo_valid;
        hs   = dispatch_valid && dispatch_ready;
        ev   = cur_is_even_character;
        pc_s = dispatch_pc;
        ch_s = dispatch_char;
        @(posedge clk);
        if (smp_cur_pop) begin
            if (ev) even_q.delete(0);
            else odd_q.delete(0);
        end
        if (smp_next_pop) begin
            if (ev) odd_q.delete(0);
            else even_q.delete(0);
        end
        if (hs) begin
            n_disp++;
            pending++;
            chk("disp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("disp_pc", pc_s, e.pc);
                chk("disp_char", ch_s, e.ch);
            end
        end
        if (retire) pending--;
        @(negedge clk);
        drive_fifos();
    endtask

    task automatic finish_run(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            retire = (pending > 0);
            cycle();
            k++;
        end
        retire = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic do_start(input int pc);
        start_pc = DW'(pc);
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        n_disp   = 0;
    endtask

    task automatic give_char(input logic [HW-1:0] c, input logic last);
        char_in_valid = 1'b1;
        char_in_data  = c;
        char_in_last  = last;
        cycle();
        char_in_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; pending = 0; n_disp = 0;
        rst = 1'b1; start = 1'b0; start_pc = '0;
        char_in_valid = 1'b0; char_in_data = '0; char_in_last = 1'b0;
        cur_fifo_valid = 1'b0; cur_fifo_data = '0;
        next_fifo_valid = 1'b0; next_fifo_count = '0;
        dispatch_ready = 1'b0; retire = 1'b0; accept = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_dvalid", dispatch_valid, 0);
        chk("rst_even", cur_is_even_character, 1);
        chk("rst_cin_rdy", char_in_ready, 0);
        chk("rst_char", dispatch_char, 0);
        rst = 1'b0;
        cycle();
        chk("idle_cin_rdy", char_in_ready, 0);

        // Single-character string "a", nothing pushed by the engine.
        dispatch_ready = 1'b1;
        do_start(0);
        chk("t1_fetch_rdy", char_in_ready, 1);
        exp_disp(0, "a");
        give_char("a", 1'b1);
        chk("t1_first_dvalid", dispatch_valid, 1);
        finish_run("t1", 40);
        chk("t1_match", match, 0);
        chk("t1_even", cur_is_even_character, 1);
        chk("t1_ndisp", n_disp, 1);

        // "ab": PC 3 pushed for 'b' while 'a' executes; swap stalls 10 cycles.
        do_start(5);
        chk("t2_done_clr", done, 0);
        exp_disp(5, "a");
        give_char("a", 1'b0);
        cycle();
        push_next(3);
        exp_disp(3, "b");
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        cycle();
        chk("t2_swap_rdy", char_in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t2_stall_even", cur_is_even_character, 1);
            chk("t2_stall_dvalid", dispatch_valid, 0);
        end
        chk("t2_stall_ndisp", n_disp, 1);
        give_char("b", 1'b1);
        chk("t2_toggled", cur_is_even_character, 0);
        finish_run("t2", 40);
        chk("t2_match", match, 0);
        chk("t2_ndisp", n_disp, 2);

        // Accept with 4 in cur FIFO, 2 in next FIFO and 2 in flight.
        push_cur(10);
        do_start(7);
        exp_disp(7, "c");
        exp_disp(10, "c");
        give_char("c", 1'b0);
        cycle();
        cycle();
        chk("t3_inflight", dut.inflight, pending);
        for (int i = 20; i < 24; i++) push_cur(i);
        push_next(30);
        push_next(31);
        accept = 1'b1;
        cycle();
        accept = 1'b0;
        chk("t3_no_pop_on_accept", smp_cur_pop, 0);
        chk("t3_match_set", match, 1);
        cycle();
        chk("t3_drain_cpop", smp_cur_pop, 1);
        chk("t3_drain_npop", smp_next_pop, 1);
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        cycle();
        cycle();
        chk("t3_fifos_empty", even_q.size() + odd_q.size(), 0);
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        chk("t3_done_wait", done, 0);
        cycle();
        chk("t3_done", done, 1);
        chk("t3_match", match, 1);
        chk("t3_ndisp", n_disp, 2);

        // Dispatch backpressure, then pops limited at 3 in flight.
        for (int i = 41; i < 46; i++) push_cur(i);
        dispatch_ready = 1'b0;
        do_start(40);
        for (int i = 40; i < 46; i++) exp_disp(i, "d");
        give_char("d", 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_hold_valid", dispatch_valid, 1);
            chk("t4_hold_pc", dispatch_pc, 40);
            chk("t4_hold_nopop", smp_cur_pop, 0);
        end
        dispatch_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        cycle();
        chk("t4_max_nopop", smp_cur_pop, 0);
        chk("t4_max_dvalid", dispatch_valid, 0);
        chk("t4_max_inflight", dut.inflight, pending);
        cycle();
        chk("t4_max_nopop2", smp_cur_pop, 0);
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        cycle();
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        chk("t4_coinc_inflight", dut.inflight, pending);
        chk("t4_coinc_ndisp", n_disp, 4);
        finish_run("t4", 60);
        chk("t4_match", match, 0);

        // Reset in RUN with 3 in flight, then a clean run.
        for (int i = 51; i < 54; i++) push_cur(i);
        do_start(50);
        for (int i = 50; i < 53; i++) exp_disp(i, "e");
        give_char("e", 1'b0);
        cycle();
        cycle();
        cycle();
        chk("t5_inflight", dut.inflight, 3);
        rst = 1'b1;
        char_in_valid = 1'b1;
        cycle();
        chk("t5_rst_done", done, 0);
        chk("t5_rst_match", match, 0);
        chk("t5_rst_dvalid", dispatch_valid, 0);
        chk("t5_rst_even", cur_is_even_character, 1);
        chk("t5_rst_cin_rdy", char_in_ready, 0);
        chk("t5_rst_cur_rdy", cur_fifo_ready, 0);
        chk("t5_rst_next_rdy", next_fifo_ready, 0);
        chk("t5_rst_char", dispatch_char, 0);
        chk("t5_rst_inflight", dut.inflight, 0);
        rst = 1'b0;
        char_in_valid = 1'b0;
        even_q.delete();
        odd_q.delete();
        sb.delete();
        pending = 0;
        cycle();
        do_start(60);
        exp_disp(60, "z");
        give_char("z", 1'b1);
        finish_run("t5", 40);
        chk("t5_match", match, 0);
        chk("t5_ndisp", n_disp, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
